// File: rtl/agv_task_scheduler_pkg.sv
// Shared types for the AGV mission sequencer: node codes, leg/state enums,
// gripper command codes and the queued task record.
package agv_pkg;
  typedef logic [7:0] node_t;

  typedef enum logic [1:0] {LEG_HOME, LEG_PICK, LEG_DROP} leg_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PLAN, S_WAIT_PATH, S_TRAVEL, S_BLOCKED, S_DWELL
  } state_e;

  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_PICK = 2'b01;
  localparam logic [1:0] LOAD_DROP = 2'b10;

  typedef struct packed {
    node_t pick;
    node_t drop;
  } task_t;
endpackage

// File: rtl/agv_task_scheduler_if.sv
// Task intake handshake plus the planner leg request/response bundle.
interface agv_task_scheduler_if;
  import agv_pkg::*;

  logic  task_valid;
  logic  task_ready;
  node_t task_pick;
  node_t task_drop;
  logic  path_ready;
  logic  plan_req;
  node_t src;
  node_t dest;

  modport master (
    output task_valid, task_pick, task_drop, path_ready,
    input  task_ready, plan_req, src, dest
  );

  modport slave (
    input  task_valid, task_pick, task_drop, path_ready,
    output task_ready, plan_req, src, dest
  );
endinterface

// File: rtl/agv_task_scheduler_fifo.sv
// Synchronous FIFO of {pick,drop} tasks; head is visible on dout while non-empty.
module agv_task_fifo import agv_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  task_t                  din,
  output task_t                  dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  task_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/agv_task_scheduler.sv
// Mission sequencer: pops pick/drop tasks and drives planner legs pick -> drop -> home,
// with arrival detection, load/unload dwell and obstacle halt. All outputs come from flops.
module agv_task_scheduler import agv_pkg::*; #(
  parameter int    FIFO_DEPTH   = 4,
  parameter node_t HOME_NODE    = 8'h60,
  parameter int    DWELL_CYCLES = 25000000,
  parameter int    PATH_TIMEOUT = 1000,
  parameter int    OBJ_CLEAR    = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  agv_task_scheduler_if.slave         bus,
  input  node_t                       current_node,
  input  logic                        node_arrive,
  input  logic                        obj_det,
  output logic                        halt,
  output logic [1:0]                  load_cmd,
  output logic                        busy,
  output logic                        task_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int PW = (PATH_TIMEOUT > 1) ? $clog2(PATH_TIMEOUT) : 1;
  localparam int CW = (OBJ_CLEAR    > 1) ? $clog2(OBJ_CLEAR)    : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PATH_LAST  = PW'(PATH_TIMEOUT - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(OBJ_CLEAR - 1);

  state_e        state_q, state_d;
  leg_e          leg_q, leg_d;
  node_t         src_q, src_d, dest_q, dest_d, drop_q, drop_d;
  logic          plan_req_q, halt_q, done_q, done_d, arr_pend_q, arr_pend_d;
  logic [1:0]    load_q;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [PW-1:0] path_cnt_q, path_cnt_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;

  task_t fifo_head;
  logic  fifo_full, fifo_empty, pop, arrived;

  // Pop is decided from registered state only, so task_ready has no input-to-output path.
  assign bus.task_ready = !fifo_full || pop;
  assign bus.plan_req   = plan_req_q;
  assign bus.src        = src_q;
  assign bus.dest       = dest_q;
  assign halt           = halt_q;
  assign load_cmd       = load_q;
  assign task_done      = done_q;
  assign busy           = (state_q != S_IDLE);
  assign arrived        = arr_pend_q && (current_node == dest_q);

  agv_task_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.task_valid && bus.task_ready),
    .pop   (pop),
    .din   ({bus.task_pick, bus.task_drop}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    leg_d       = leg_q;
    src_d       = src_q;
    dest_d      = dest_q;
    drop_d      = drop_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    arr_pend_d  = 1'b0;
    dwell_cnt_d = '0;
    path_cnt_d  = '0;
    clr_cnt_d   = '0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        leg_d   = LEG_PICK;
        src_d   = current_node;
        dest_d  = fifo_head.pick;
        drop_d  = fifo_head.drop;
        state_d = S_PLAN;
      end
      S_PLAN: state_d = S_WAIT_PATH;
      S_WAIT_PATH: begin
        if (bus.path_ready)            state_d = S_TRAVEL;
        else if (path_cnt_q == PATH_LAST) state_d = S_PLAN;
        else                           path_cnt_d = path_cnt_q + 1'b1;
      end
      S_TRAVEL, S_BLOCKED: begin
        // current_node settles on the arrival cycle, so the compare runs one cycle later.
        arr_pend_d = node_arrive;
        if (arrived) begin
          arr_pend_d = 1'b0;
          state_d    = (leg_q == LEG_HOME) ? S_IDLE : S_DWELL;
        end else if (state_q == S_TRAVEL) begin
          if (obj_det) state_d = S_BLOCKED;
        end else if (!obj_det) begin
          if (clr_cnt_q == CLR_LAST) state_d = S_TRAVEL;
          else                       clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_DWELL: begin
        if (dwell_cnt_q == DWELL_LAST) begin
          src_d   = dest_q;
          state_d = S_PLAN;
          if (leg_q == LEG_PICK) begin
            leg_d  = LEG_DROP;
            dest_d = drop_q;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              pop    = 1'b1;
              leg_d  = LEG_PICK;
              dest_d = fifo_head.pick;
              drop_d = fifo_head.drop;
            end else begin
              leg_d  = LEG_HOME;
              dest_d = HOME_NODE;
            end
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A zero-length leg is already "arrived": skip the planner entirely.
    if (state_d == S_PLAN && state_q != S_WAIT_PATH && src_d == dest_d)
      state_d = (leg_d == LEG_HOME) ? S_IDLE : S_DWELL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      leg_q       <= LEG_HOME;
      src_q       <= HOME_NODE;
      dest_q      <= HOME_NODE;
      drop_q      <= HOME_NODE;
      plan_req_q  <= 1'b0;
      halt_q      <= 1'b1;
      load_q      <= LOAD_NONE;
      done_q      <= 1'b0;
      arr_pend_q  <= 1'b0;
      dwell_cnt_q <= '0;
      path_cnt_q  <= '0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      leg_q       <= leg_d;
      src_q       <= src_d;
      dest_q      <= dest_d;
      drop_q      <= drop_d;
      plan_req_q  <= (state_d == S_PLAN);
      halt_q      <= (state_d != S_TRAVEL);
      load_q      <= (state_d != S_DWELL) ? LOAD_NONE :
                     (leg_d == LEG_PICK)  ? LOAD_PICK : LOAD_DROP;
      done_q      <= done_d;
      arr_pend_q  <= arr_pend_d;
      dwell_cnt_q <= dwell_cnt_d;
      path_cnt_q  <= path_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end
endmodule
